// File: rtl/read_channel_arbiter_if.sv
// Bundle between the refill requesters, the arbiter and the shared AXI read channel.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface read_channel_arbiter_if #(
  parameter int N_MASTERS  = 2,
  parameter int REP_ADDR_W = 27,
  parameter int LINE2MEM_W = 3,
  parameter int BE_DATA_W  = 32
);
  logic [N_MASTERS-1:0]            m_replace_valid;
  logic [N_MASTERS*REP_ADDR_W-1:0] m_replace_addr;
  logic [N_MASTERS-1:0]            m_replace_ready;
  logic [N_MASTERS-1:0]            m_read_valid;
  logic [LINE2MEM_W-1:0]           m_read_addr;
  logic [BE_DATA_W-1:0]            m_read_rdata;
  logic                            be_replace_valid;
  logic [REP_ADDR_W-1:0]           be_replace_addr;
  logic                            be_replace_ready;
  logic                            be_read_valid;
  logic [LINE2MEM_W-1:0]           be_read_addr;
  logic [BE_DATA_W-1:0]            be_read_rdata;

  modport slave (
    input  m_replace_valid, m_replace_addr,
    input  be_replace_ready, be_read_valid, be_read_addr, be_read_rdata,
    output m_replace_ready, m_read_valid, m_read_addr, m_read_rdata,
    output be_replace_valid, be_replace_addr
  );

  modport master (
    output m_replace_valid, m_replace_addr,
    output be_replace_ready, be_read_valid, be_read_addr, be_read_rdata,
    input  m_replace_ready, m_read_valid, m_read_addr, m_read_rdata,
    input  be_replace_valid, be_replace_addr
  );
endinterface

// File: rtl/read_channel_arbiter.sv
// Shares one line-refill read channel among N_MASTERS requesters, holding the grant for a whole burst.
// Round-robin by default; define RD_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module read_channel_arbiter #(
  parameter int N_MASTERS  = 2,
  parameter int REP_ADDR_W = 27,
  parameter int LINE2MEM_W = 3,
  parameter int BE_DATA_W  = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  read_channel_arbiter_if.slave  bus
);

  localparam int IDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, WAIT_DONE} state_t;

  state_t                 state_q, state_d;
  logic [N_MASTERS-1:0]   grant_q, grant_d;
  logic [REP_ADDR_W-1:0]  addr_q, addr_d;
  logic [IDX_W-1:0]       start_idx;
  logic [IDX_W-1:0]       sel_idx;
  logic                   sel_found;
  logic                   be_replace_valid;
  logic [N_MASTERS-1:0]   m_replace_ready;

  // Index base+k wrapped into 0..N_MASTERS-1 (k is always < N_MASTERS here).
  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N_MASTERS) s = s - N_MASTERS;
    return IDX_W'(s);
  endfunction

`ifndef RD_ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] grant_idx;

  assign start_idx = rr_ptr_q;

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (grant_q[i]) grant_idx = IDX_W'(i);
    end
  end
`else
  assign start_idx = '0;
`endif

  // First pending requester at or after start_idx, wrapping.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = 0; k < N_MASTERS; k++) begin
      if (!sel_found && bus.m_replace_valid[wrap_idx(start_idx, k)]) begin
        sel_found = 1'b1;
        sel_idx   = wrap_idx(start_idx, k);
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    grant_d          = grant_q;
    addr_d           = addr_q;
`ifndef RD_ARB_FIXED_PRIO_EN
    rr_ptr_d         = rr_ptr_q;
`endif
    be_replace_valid = 1'b0;
    m_replace_ready  = '0;
    unique case (state_q)
      IDLE: begin
        if (sel_found && bus.be_replace_ready) begin
          grant_d = {{(N_MASTERS-1){1'b0}}, 1'b1} << sel_idx;
          addr_d  = bus.m_replace_addr[sel_idx*REP_ADDR_W +: REP_ADDR_W];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        be_replace_valid = 1'b1;
        state_d          = BUSY;
      end
      BUSY: begin
        if (!bus.be_replace_ready) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        // Ready low here also covers a slave-error retry: keep holding the grant.
        if (bus.be_replace_ready) begin
          m_replace_ready = grant_q;
          grant_d         = '0;
`ifndef RD_ARB_FIXED_PRIO_EN
          rr_ptr_d        = wrap_idx(grant_idx, 1);
`endif
          state_d         = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      addr_q   <= '0;
`ifndef RD_ARB_FIXED_PRIO_EN
      rr_ptr_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      addr_q   <= addr_d;
`ifndef RD_ARB_FIXED_PRIO_EN
      rr_ptr_q <= rr_ptr_d;
`endif
    end
  end

  assign bus.be_replace_valid = be_replace_valid;
  assign bus.be_replace_addr  = addr_q;
  assign bus.m_replace_ready  = m_replace_ready;
  assign bus.m_read_valid     = {N_MASTERS{bus.be_read_valid}} & grant_q;
  assign bus.m_read_addr      = bus.be_read_addr;
  assign bus.m_read_rdata     = bus.be_read_rdata;

endmodule

// File: tb/tb_read_channel_arbiter.sv
// Bench for read_channel_arbiter: vector table, directed corner sequences, and randomized
// bursts checked against a pending-set/pointer model of the arbitration rules.
module tb_read_channel_arbiter;

  localparam int N  = 2;
  localparam int AW = 27;
  localparam int LW = 3;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  read_channel_arbiter_if #(.N_MASTERS(N), .REP_ADDR_W(AW), .LINE2MEM_W(LW), .BE_DATA_W(DW)) bus ();

  read_channel_arbiter #(.N_MASTERS(N), .REP_ADDR_W(AW), .LINE2MEM_W(LW), .BE_DATA_W(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int            prime;
    logic [N-1:0]  req;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    int            exp_rr;
    int            exp_fp;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    bus.m_replace_addr[i*AW +: AW] = a;
  endtask

  task automatic idle_drives();
    bus.m_replace_valid  = '0;
    bus.be_replace_ready = 1'b1;
    bus.be_read_valid    = 1'b0;
    bus.be_read_addr     = '0;
    bus.be_read_rdata    = '0;
  endtask

  // Leaves the bench at posedge+1 with reset released.
  task automatic do_reset();
    reset = 1'b1;
    idle_drives();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Plays the read channel for one burst and checks the arbiter around it.
  // Entered and left at posedge+1 with the arbiter idle.
  task automatic serve_burst(input int exp_idx, input logic [AW-1:0] exp_addr, input int lat,
                             input int stall, input logic chg, input logic [AW-1:0] chg_val,
                             input logic drop, input string tag);
    int waited;
    int bad_v, bad_p, bad_r;
    logic [DW-1:0] d;
    waited = 0;
    bad_v = 0; bad_p = 0; bad_r = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!bus.be_replace_valid && waited < 20);
    if (!bus.be_replace_valid) begin
      check({tag, "_grant_timeout"}, 64'(waited), 64'(2));
      return;
    end
    check({tag, "_grant_lat"}, 64'(waited), 64'(2));
    check({tag, "_issue_addr"}, 64'(bus.be_replace_addr), 64'(exp_addr));
    @(posedge clk); #1 bus.be_replace_ready = 1'b0;
    @(negedge clk);
    check({tag, "_issue_one_cycle"}, 64'(bus.be_replace_valid), 64'(0));
    for (int i = 0; i < lat; i++) begin
      @(posedge clk); #1;
    end
    for (int b = 0; b < 8; b++) begin
      @(posedge clk); #1;
      d = DW'($urandom);
      bus.be_read_valid = 1'b1;
      bus.be_read_addr  = LW'(b);
      bus.be_read_rdata = d;
      if (chg && b == 0) set_addr(1, chg_val);
      @(negedge clk);
      if (bus.m_read_valid !== oh(exp_idx)) bad_v++;
      if (bus.m_read_addr !== LW'(b) || bus.m_read_rdata !== d) bad_p++;
      if (bus.m_replace_ready !== '0 || bus.be_replace_valid !== 1'b0) bad_r++;
    end
    @(posedge clk); #1 bus.be_read_valid = 1'b0;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      if (bus.m_replace_ready !== '0 || bus.be_replace_valid !== 1'b0) bad_r++;
      @(posedge clk); #1;
    end
    bus.be_replace_ready = 1'b1;
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(bus.m_replace_ready), 64'(oh(exp_idx)));
    check({tag, "_hold_addr"}, 64'(bus.be_replace_addr), 64'(exp_addr));
    check({tag, "_strobe_beats_bad"}, 64'(bad_v), 64'(0));
    check({tag, "_passthru_bad"}, 64'(bad_p), 64'(0));
    check({tag, "_early_done_or_issue"}, 64'(bad_r), 64'(0));
    @(posedge clk); #1;
    if (drop) bus.m_replace_valid[exp_idx] = 1'b0;
  endtask

  vec_t          vecs[7];
  int            exp_i;
  int            waited;
  logic [N-1:0]  pend;
  logic [AW-1:0] maddr[N];
  int            ptr;
  logic          keep;

  initial begin
    vecs[0] = '{-1, 2'b01, 27'h1234, 27'h0555, 0, 0};
    vecs[1] = '{-1, 2'b10, 27'h1234, 27'h0555, 1, 1};
    vecs[2] = '{-1, 2'b11, 27'h0F00, 27'h0E00, 0, 0};
    vecs[3] = '{ 0, 2'b11, 27'h0101, 27'h0202, 1, 0};
    vecs[4] = '{ 1, 2'b11, 27'h0303, 27'h0404, 0, 0};
    vecs[5] = '{ 1, 2'b01, 27'h0505, 27'h0606, 0, 0};
    vecs[6] = '{ 0, 2'b10, 27'h0707, 27'h0808, 1, 1};

    // Reset state, with a live read strobe that must not reach any master.
    reset = 1'b1;
    idle_drives();
    bus.m_replace_addr = '0;
    bus.m_replace_valid = 2'b11;
    bus.be_read_valid = 1'b1;
    bus.be_read_addr = 3'd5;
    bus.be_read_rdata = 32'hDEADBEEF;
    @(negedge clk);
    check("rst_be_replace_valid", 64'(bus.be_replace_valid), 64'(0));
    check("rst_be_replace_addr", 64'(bus.be_replace_addr), 64'(0));
    check("rst_m_replace_ready", 64'(bus.m_replace_ready), 64'(0));
    check("rst_m_read_valid", 64'(bus.m_read_valid), 64'(0));
    check("rst_read_addr_pass", 64'(bus.m_read_addr), 64'(5));
    check("rst_read_data_pass", 64'(bus.m_read_rdata), 64'h0000_0000_DEAD_BEEF);
    do_reset();

    // Vector table: optional priming burst, then a request pattern with a known winner.
    for (int v = 0; v < 7; v++) begin
      do_reset();
      set_addr(0, vecs[v].a0);
      set_addr(1, vecs[v].a1);
      if (vecs[v].prime >= 0) begin
        bus.m_replace_valid = oh(vecs[v].prime);
        serve_burst(vecs[v].prime, vecs[v].prime == 0 ? vecs[v].a0 : vecs[v].a1,
                    1, 0, 1'b0, '0, 1'b1, $sformatf("vec%0d_prime", v));
      end
      bus.m_replace_valid = vecs[v].req;
`ifdef RD_ARB_FIXED_PRIO_EN
      exp_i = vecs[v].exp_fp;
`else
      exp_i = vecs[v].exp_rr;
`endif
      serve_burst(exp_i, exp_i == 0 ? vecs[v].a0 : vecs[v].a1, 3, 1, 1'b0, '0, 1'b1,
                  $sformatf("vec%0d", v));
    end

    // Both masters hold their requests across four bursts.
    do_reset();
    set_addr(0, 27'h0C00);
    set_addr(1, 27'h0D00);
    bus.m_replace_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
`ifdef RD_ARB_FIXED_PRIO_EN
      exp_i = 0;
`else
      exp_i = k % 2;
`endif
      serve_burst(exp_i, exp_i == 0 ? 27'h0C00 : 27'h0D00, 0, 0, 1'b0, '0, 1'b0,
                  $sformatf("held%0d", k));
    end

    // Address changes during the burst must not reach the read channel.
    do_reset();
    set_addr(1, 27'h0AAA);
    bus.m_replace_valid = 2'b10;
    serve_burst(1, 27'h0AAA, 2, 2, 1'b1, 27'h0BBB, 1'b1, "addr_stable");

    // Long slave-error retry while master 1 waits.
    do_reset();
    set_addr(0, 27'h1111);
    set_addr(1, 27'h2222);
    bus.m_replace_valid = 2'b11;
    serve_burst(0, 27'h1111, 1, 20, 1'b0, '0, 1'b1, "retry");
    serve_burst(1, 27'h2222, 1, 0, 1'b0, '0, 1'b1, "after_retry");

    // Reset during beat 3 of master 0's burst.
    do_reset();
    set_addr(0, 27'h0111);
    set_addr(1, 27'h0222);
    bus.m_replace_valid = 2'b01;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!bus.be_replace_valid && waited < 20);
    check("mid_rst_grant_seen", 64'(bus.be_replace_valid), 64'(1));
    @(posedge clk); #1 bus.be_replace_ready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      @(posedge clk); #1;
      bus.be_read_valid = 1'b1;
      bus.be_read_addr  = LW'(b);
    end
    #1;
    check("mid_rst_pre_strobe", 64'(bus.m_read_valid), 64'(2'b01));
    reset = 1'b1;
    #1;
    check("mid_rst_be_valid", 64'(bus.be_replace_valid), 64'(0));
    check("mid_rst_strobe", 64'(bus.m_read_valid), 64'(0));
    check("mid_rst_done", 64'(bus.m_replace_ready), 64'(0));
    idle_drives();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    bus.m_replace_valid = 2'b10;
    serve_burst(1, 27'h0222, 1, 0, 1'b0, '0, 1'b1, "post_rst");

    // Randomized bursts against a pending-set model.
    do_reset();
    pend = '0;
    ptr  = 0;
    for (int i = 0; i < N; i++) maddr[i] = '0;
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i]  = 1'b1;
          maddr[i] = AW'($urandom);
        end
      end
      if (pend == '0) begin
        exp_i = int'($urandom_range(0, N - 1));
        pend[exp_i]  = 1'b1;
        maddr[exp_i] = AW'($urandom);
      end
      for (int i = 0; i < N; i++) set_addr(i, maddr[i]);
      bus.m_replace_valid = pend;
      exp_i = -1;
      for (int k = 0; k < N; k++) begin
        if (exp_i < 0 && pend[(ptr + k) % N]) exp_i = (ptr + k) % N;
      end
      keep = ($urandom_range(0, 3) == 0);
      serve_burst(exp_i, maddr[exp_i], int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  1'b0, '0, !keep, $sformatf("rand%0d", t));
      if (!keep) pend[exp_i] = 1'b0;
`ifndef RD_ARB_FIXED_PRIO_EN
      ptr = (exp_i + 1) % N;
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
